// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding and the NOP word
// that a flushed pipeline register is loaded with.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    ST_RSVD    = 2'd3
  } pipe_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int LU_CNT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear that sticks at its maximum value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clr)
      r_q <= '0;
    else if (en && (r_q != {W{1'b1}}))
      r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and memory-busy freezes,
// with saturating stall/flush statistics.
module hazard_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LU_STALL_CYCLES - 1);

  pipe_state_t             r_state, w_state_nxt;
  pipe_state_t             r_ret,   w_ret_nxt;
  logic [LU_CNT_W-1:0]     r_lu_cnt, w_lu_cnt_nxt;
  logic                    w_lu_haz;
  logic                    w_flush_evt;

  assign w_lu_haz = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_ret    <= RUN;
      r_lu_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ret    <= w_ret_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_hold    = 1'b0;
    w_flush_evt  = 1'b0;
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_lu_cnt_nxt = r_lu_cnt;

    case (r_state)
      RUN: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_ret_nxt   = RUN;
        end else if (branch_taken) begin
          // The dependent instruction is squashed, so a coincident hazard is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_flush_evt = 1'b1;
        end else if (w_lu_haz) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (LU_STALL_CYCLES > 1) begin
            w_state_nxt  = LOAD_STALL;
            w_lu_cnt_nxt = LU_RELOAD;
          end
        end
      end
      LOAD_STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if (mem_busy) begin
          pipe_hold   = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_ret_nxt   = LOAD_STALL;
        end else begin
          id_ex_flush  = 1'b1;
          w_lu_cnt_nxt = r_lu_cnt - 1'b1;
          if (r_lu_cnt <= LU_CNT_W'(1))
            w_state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
        // The release cycle still holds; the return state acts next cycle.
        if (!mem_busy)
          w_state_nxt = r_ret;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pipe_hold   = 1'b0;
      w_flush_evt = 1'b0;
    end
  end

  assign state = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .en  (!pc_write),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .en  (w_flush_evt),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three parameterisations share one stimulus.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_ex_rt;
  logic       id_uses_rt, id_ex_mem_read, branch_taken, mem_busy;

  logic        a_pcw, a_ifw, a_iff, a_exf, a_hold;
  logic [1:0]  a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_pcw, b_ifw, b_iff, b_exf, b_hold;
  logic [1:0]  b_st;
  logic [15:0] b_sc, b_fc;
  logic        c_pcw, c_ifw, c_iff, c_exf, c_hold;
  logic [1:0]  c_st;
  logic [3:0]  c_sc, c_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(16), .LU_STALL_CYCLES(1)) u_lu1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_iff),
    .id_ex_flush(a_exf), .pipe_hold(a_hold), .state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc));

  hazard_control_unit #(.CNT_W(16), .LU_STALL_CYCLES(3)) u_lu3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_iff),
    .id_ex_flush(b_exf), .pipe_hold(b_hold), .state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc));

  hazard_control_unit #(.CNT_W(4), .LU_STALL_CYCLES(1)) u_cnt4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write(c_pcw), .if_id_write(c_ifw), .if_id_flush(c_iff),
    .id_ex_flush(c_exf), .pipe_hold(c_hold), .state(c_st), .stall_cnt(c_sc), .flush_cnt(c_fc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and clear all pipeline inputs.
  task automatic idle();
    @(negedge clk);
    reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_ex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    idle();
  endtask

  initial begin
    reset = 1'b1; id_rs = '0; id_rt = '0; id_ex_rt = '0;
    id_uses_rt = 0; id_ex_mem_read = 0; branch_taken = 0; mem_busy = 0;
    repeat (2) @(negedge clk);

    // 1: enter MEM_WAIT, then hold reset for two cycles
    idle(); mem_busy = 1'b1;
    idle(); #1;
    chk("t1_in_memwait", 32'(a_st), 32'd2);
    mem_busy = 1'b1; reset = 1'b1; #1;
    chk("t1_rst_pcw",  32'(a_pcw), 32'd0);
    chk("t1_rst_ifw",  32'(a_ifw), 32'd0);
    chk("t1_rst_iff",  32'(a_iff), 32'd1);
    chk("t1_rst_exf",  32'(a_exf), 32'd1);
    chk("t1_rst_hold", 32'(a_hold), 32'd0);
    @(negedge clk); #1;
    chk("t1_rst2_pcw", 32'(a_pcw), 32'd0);
    chk("t1_rst2_iff", 32'(a_iff), 32'd1);
    idle(); #1;
    chk("t1_state", 32'(a_st), 32'd0);
    chk("t1_stall", 32'(a_sc), 32'd0);
    chk("t1_flush", 32'(a_fc), 32'd0);
    chk("t1_pcw",   32'(a_pcw), 32'd1);

    // 2: single load-use bubble with LU=1
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5; #1;
    chk("t2_pcw", 32'(a_pcw), 32'd0);
    chk("t2_ifw", 32'(a_ifw), 32'd0);
    chk("t2_exf", 32'(a_exf), 32'd1);
    chk("t2_iff", 32'(a_iff), 32'd0);
    idle(); #1;
    chk("t2_pcw_after", 32'(a_pcw), 32'd1);
    chk("t2_stall",     32'(a_sc), 32'd1);
    chk("t2_state",     32'(a_st), 32'd0);

    // 3: r0 destination and unused rt never stall
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; id_rs = 5'd0; #1;
    chk("t3_r0_pcw", 32'(a_pcw), 32'd1);
    idle();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0; #1;
    chk("t3_rt_unused_pcw", 32'(a_pcw), 32'd1);
    idle(); #1;
    chk("t3_stall0", 32'(a_sc), 32'd0);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1; #1;
    chk("t3_rt_used_pcw", 32'(a_pcw), 32'd0);
    idle(); #1;
    chk("t3_stall1", 32'(a_sc), 32'd1);

    // 4: branch beats load-use
    do_reset();
    branch_taken = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5; #1;
    chk("t4_pcw", 32'(a_pcw), 32'd1);
    chk("t4_iff", 32'(a_iff), 32'd1);
    chk("t4_exf", 32'(a_exf), 32'd1);
    idle(); #1;
    chk("t4_flush", 32'(a_fc), 32'd1);
    chk("t4_stall", 32'(a_sc), 32'd0);
    chk("t4_state", 32'(a_st), 32'd0);

    // 5: LU=3, memory busy for 4 cycles after the first bubble
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; id_rs = 5'd9; #1;
    chk("t5_bub1_pcw", 32'(b_pcw), 32'd0);
    chk("t5_bub1_exf", 32'(b_exf), 32'd1);
    idle(); mem_busy = 1'b1; #1;
    chk("t5_busy1_state", 32'(b_st), 32'd1);
    chk("t5_busy1_hold",  32'(b_hold), 32'd1);
    chk("t5_busy1_exf",   32'(b_exf), 32'd0);
    chk("t5_busy1_pcw",   32'(b_pcw), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      idle(); mem_busy = 1'b1; #1;
      chk($sformatf("t5_busy%0d_state", i), 32'(b_st), 32'd2);
      chk($sformatf("t5_busy%0d_hold", i),  32'(b_hold), 32'd1);
    end
    idle(); #1;
    chk("t5_exit_state", 32'(b_st), 32'd2);
    chk("t5_exit_hold",  32'(b_hold), 32'd1);
    chk("t5_exit_pcw",   32'(b_pcw), 32'd0);
    idle(); #1;
    chk("t5_bub2_state", 32'(b_st), 32'd1);
    chk("t5_bub2_exf",   32'(b_exf), 32'd1);
    chk("t5_bub2_hold",  32'(b_hold), 32'd0);
    idle(); #1;
    chk("t5_bub3_state", 32'(b_st), 32'd1);
    chk("t5_bub3_pcw",   32'(b_pcw), 32'd0);
    idle(); #1;
    chk("t5_run_state", 32'(b_st), 32'd0);
    chk("t5_run_pcw",   32'(b_pcw), 32'd1);
    chk("t5_stall",     32'(b_sc), 32'd8);

    // 6: 4-bit stall counter saturates
    do_reset();
    for (int i = 0; i < 14; i++) begin
      mem_busy = 1'b1;
      @(negedge clk);
    end
    #1 chk("t6_stall14", 32'(c_sc), 32'd14);
    for (int i = 0; i < 6; i++) begin
      mem_busy = 1'b1;
      @(negedge clk);
    end
    #1 chk("t6_stall_sat", 32'(c_sc), 32'd15);
    idle(); idle(); #1;
    chk("t6_stall_sat_hold", 32'(c_sc), 32'd15);
    chk("t6_state", 32'(c_st), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
